spi_flash_sr_responder: RTL and testbench
=========================================

SPI_FLASH_SR_RESPONDER -- requirements
Module: spi_flash_sr_responder

Interface
REQ-001 Parameter BUSY_CYCLES, default 64: ACLK cycles the WIP bit stays set after a busy_req pulse; range 1..65535.
REQ-002 Parameter SR_UPPER, default 6'b000000: constant value returned in status bits [7:2].
REQ-003 ACLK  input  1  single clock; all ports are synchronous to it, including the SPI pins driven by the master on the same clock.
REQ-004 ARESETn  input  1  asynchronous active-low reset.
REQ-005 CS  input  1  SPI chip select, active low.
REQ-006 CLOCK  input  1  SPI serial clock, mode 0 (idle low); at most ACLK/2.
REQ-007 IO0  input  1  MOSI; command bits, MSB first.
REQ-008 io1_out  output  1  MISO data value; registered.
REQ-009 io1_oe  output  1  MISO output enable; the top level builds the IO1 tristate from io1_out/io1_oe.
REQ-010 busy_req  input  1  one-cycle pulse that starts an emulated program/erase operation.
REQ-011 status_reg  output  8  live status register {SR_UPPER, WEL, WIP}.
REQ-012 cmd_strobe  output  1  one-cycle pulse when a command is accepted.
REQ-013 cmd_code  output  8  opcode of the last accepted command.

Function
REQ-014 SCK edges are detected against a registered copy of CLOCK: rise = CLOCK & ~clk_q; fall = ~CLOCK & clk_q; no synchronizers.
REQ-015 FSM states: IDLE, CMD, RDSR_OUT, IGNORE.
REQ-016 IDLE: io1_oe=0 and bit counter cleared; CS low moves to CMD in the same cycle it is sampled low.
REQ-017 CMD: on each rise, shift IO0 into the opcode register and increment the 3-bit counter; when the 8th rise completes, decode the opcode.
REQ-018 Opcode 0x05 (RDSR): assert cmd_strobe and cmd_code=0x05 on the cycle after the 8th rise, then go to RDSR_OUT.
REQ-019 Opcodes 0x06 (WREN) and 0x04 (WRDI): go to IGNORE with the opcode pending; commit only on a CS rise with no further rise since the 8th.
REQ-020 WREN commit sets WEL; WRDI commit clears WEL; either commit pulses cmd_strobe and updates cmd_code.
REQ-021 A WREN or WRDI commit is discarded without a strobe if WIP=1 in the commit cycle.
REQ-022 Any other opcode goes to IGNORE; CS rising returns to IDLE with no strobe and no state change.
REQ-023 RDSR_OUT: io1_oe=1; on the first fall, load a status_reg snapshot and drive bit7; on each later fall, drive the next lower bit.
REQ-024 RDSR_OUT: after bit0 has been driven, the next fall reloads a fresh snapshot and drives its bit7; the register streams until CS rises.
REQ-025 io1_out changes only on registered fall-detect; with SCK=ACLK/2 each bit is stable through the following SCK-high cycle.
REQ-026 CS high in any state returns to IDLE on the next cycle: io1_oe=0, io1_out=0, and any partial command is discarded.
REQ-027 busy_req loads the busy counter with BUSY_CYCLES; WIP=1 while the counter is nonzero; the counter decrements by 1 per cycle and saturates at 0.
REQ-028 busy_req while the counter is nonzero reloads the counter to BUSY_CYCLES.
REQ-029 When the counter transitions 1->0, clear WIP and WEL in the same cycle.
REQ-030 If a busy_req pulse and the 1->0 transition coincide, the reload wins: WIP stays 1 and WEL is unchanged.

Reset
REQ-031 ARESETn low immediately forces state=IDLE, io1_out=0, io1_oe=0, WEL=0, busy counter=0 (WIP=0), cmd_strobe=0, cmd_code=8'h00, opcode register=0, bit counter=0, clk_q=0.
REQ-032 Reset asserted mid-transfer aborts it; after release, the block waits for CS high before accepting a new command.

Verification
REQ-033 Reset, then WREN (0x06) and CS high -> cmd_strobe pulse, cmd_code=0x06, status_reg=8'h02.
REQ-034 After WREN, RDSR (0x05) for 16 SCK periods at ACLK/2 -> master samples 8'h02 twice; io1_oe=0 one cycle after CS high.
REQ-035 WREN, busy_req, immediate RDSR polling with BUSY_CYCLES=64:
- read bytes show 8'h03 while busy.
- a later byte shows 8'h00.
- the WIP and WEL bits of status_reg fall exactly 64 cycles after busy_req.
REQ-036 WREN with 9 SCK rises before CS high -> no strobe, WEL unchanged; opcode 0xAB -> no strobe, io1_oe stays 0.
REQ-037 WREN while WIP=1 -> discarded, no strobe; busy_req repeated at count 1 -> WIP held, counter reloaded to 64.
REQ-038 ARESETn low during the 4th RDSR bit -> io1_oe=0 and status_reg=8'h00 immediately; the first command after CS high decodes correctly.

Source files
------------

// File: rtl/spi_flash_sr_responder.sv
// SPI NOR status-register responder that answers RDSR, WREN and WRDI on the ACLK domain.
// It also emulates a program/erase busy window that is started by busy_req.
module spi_flash_sr_responder #(
    parameter int unsigned BUSY_CYCLES = 64,
    parameter logic [5:0]  SR_UPPER    = 6'b000000
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       CS,
    input  logic       CLOCK,
    input  logic       IO0,
    output logic       io1_out,
    output logic       io1_oe,
    input  logic       busy_req,
    output logic [7:0] status_reg,
    output logic       cmd_strobe,
    output logic [7:0] cmd_code
);
    localparam int unsigned CNT_W   = 16;
    localparam logic [7:0]  OP_RDSR = 8'h05;
    localparam logic [7:0]  OP_WREN = 8'h06;
    localparam logic [7:0]  OP_WRDI = 8'h04;

    typedef enum logic [1:0] {IDLE, CMD, RDSR_OUT, IGNORE} state_t;

    state_t           state, state_d;
    logic             clk_q;
    logic             rise_c, fall_c;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       opcode, opcode_d;
    logic [7:0]       snap, snap_d;
    logic [7:0]       cmd_code_d;
    logic             pend, pend_d;
    logic             armed, armed_d;
    logic             wel, wel_d;
    logic             wip, wip_d;
    logic             io1_out_d, io1_oe_d, cmd_strobe_d;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_d;
    logic             busy_done_c;

    assign rise_c     = CLOCK & ~clk_q;
    assign fall_c     = ~CLOCK & clk_q;
    assign status_reg = {SR_UPPER, wel, wip};

    // Busy window: a new request always wins over expiry of the old one
    always_comb begin
        busy_cnt_d = busy_cnt;
        if (busy_req) begin
            busy_cnt_d = CNT_W'(BUSY_CYCLES);
        end else if (busy_cnt != '0) begin
            busy_cnt_d = busy_cnt - CNT_W'(1);
        end
        busy_done_c = (busy_cnt == CNT_W'(1)) && !busy_req;
        wip_d       = (busy_cnt_d != '0);
    end

    // Next-state and registered-output logic for the command FSM
    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        opcode_d     = opcode;
        snap_d       = snap;
        pend_d       = pend;
        armed_d      = armed | CS;
        wel_d        = wel;
        cmd_code_d   = cmd_code;
        cmd_strobe_d = 1'b0;
        io1_out_d    = 1'b0;
        io1_oe_d     = 1'b0;

        if (CS) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (state == IGNORE && pend && !wip) begin
                cmd_strobe_d = 1'b1;
                cmd_code_d   = opcode;
                wel_d        = (opcode == OP_WREN);
            end
        end else begin
            unique case (state)
                IDLE: begin
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                    // After reset, a transfer already in progress is not joined
                    if (armed) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (rise_c) begin
                        opcode_d  = {opcode[6:0], IO0};
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_d = IGNORE;
                            if (opcode_d == OP_RDSR) begin
                                cmd_strobe_d = 1'b1;
                                cmd_code_d   = OP_RDSR;
                                state_d      = RDSR_OUT;
                            end else if (opcode_d == OP_WREN || opcode_d == OP_WRDI) begin
                                pend_d = 1'b1;
                            end else begin
                                pend_d = 1'b0;
                            end
                        end
                    end
                end
                RDSR_OUT: begin
                    io1_out_d = io1_out;
                    if (fall_c) begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd0) begin
                            io1_out_d = status_reg[7];
                            snap_d    = {status_reg[6:0], 1'b0};
                        end else begin
                            io1_out_d = snap[7];
                            snap_d    = {snap[6:0], 1'b0};
                        end
                    end
                end
                IGNORE: begin
                    if (rise_c) begin
                        pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (busy_done_c) begin
            wel_d = 1'b0;
        end
        io1_oe_d = (state_d == RDSR_OUT);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            clk_q      <= 1'b0;
            bit_cnt    <= '0;
            opcode     <= '0;
            snap       <= '0;
            pend       <= 1'b0;
            armed      <= 1'b0;
            wel        <= 1'b0;
            wip        <= 1'b0;
            busy_cnt   <= '0;
            io1_out    <= 1'b0;
            io1_oe     <= 1'b0;
            cmd_strobe <= 1'b0;
            cmd_code   <= 8'h00;
        end else begin
            state      <= state_d;
            clk_q      <= CLOCK;
            bit_cnt    <= bit_cnt_d;
            opcode     <= opcode_d;
            snap       <= snap_d;
            pend       <= pend_d;
            armed      <= armed_d;
            wel        <= wel_d;
            wip        <= wip_d;
            busy_cnt   <= busy_cnt_d;
            io1_out    <= io1_out_d;
            io1_oe     <= io1_oe_d;
            cmd_strobe <= cmd_strobe_d;
            cmd_code   <= cmd_code_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_sr_responder.sv
// Directed bench for spi_flash_sr_responder: an SPI mode-0 master at ACLK/2 with scoreboards
// for the command strobes and for the status bytes that are read back.
module tb_spi_flash_sr_responder;
    localparam int BUSY = 64;

    logic       ACLK     = 1'b0;
    logic       ARESETn  = 1'b0;
    logic       CS       = 1'b1;
    logic       CLOCK    = 1'b0;
    logic       IO0      = 1'b0;
    logic       busy_req = 1'b0;
    logic       io1_out, io1_oe, cmd_strobe;
    logic [7:0] status_reg, cmd_code;

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         busy_edge = -1;
    int         b2;
    logic       exp_wel   = 1'b0;
    logic [7:0] dummy;
    logic [7:0] strobe_q[$];
    logic [7:0] miso_q[$];

    spi_flash_sr_responder #(.BUSY_CYCLES(BUSY), .SR_UPPER(6'b000000)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .CS(CS), .CLOCK(CLOCK), .IO0(IO0),
        .io1_out(io1_out), .io1_oe(io1_oe), .busy_req(busy_req),
        .status_reg(status_reg), .cmd_strobe(cmd_strobe), .cmd_code(cmd_code)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the oldest expected command code
    always @(negedge ACLK) begin
        if (ARESETn && cmd_strobe === 1'b1) begin
            checks++;
            assert (strobe_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed=%0h expected=none", cmd_code);
            end
            if (strobe_q.size() != 0) chk("strobe_code", 16'(cmd_code), 16'(strobe_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic xfer(input logic [7:0] mosi, input bit rd, output logic [7:0] miso);
        logic [7:0] exp_b;
        for (int i = 7; i >= 0; i--) begin
            CLOCK = 1'b0;
            IO0   = mosi[i];
            tick();
            if (rd && i == 7) begin
                if (busy_edge >= 0 && (cyc - busy_edge) > BUSY) exp_b = 8'h00;
                else exp_b = {6'b0, exp_wel, (busy_edge >= 0) ? 1'b1 : 1'b0};
                miso_q.push_back(exp_b);
            end
            CLOCK   = 1'b1;
            miso[i] = io1_out;
            tick();
        end
    endtask

    task automatic rd_byte(input string tag);
        logic [7:0] b;
        xfer(8'h00, 1'b1, b);
        chk(tag, 16'(b), 16'(miso_q.pop_front()));
    endtask

    task automatic cs_low();
        CS = 1'b0;
        tick();
    endtask

    task automatic cs_high();
        CLOCK = 1'b0;
        tick();
        CS = 1'b1;
        tick();
    endtask

    task automatic simple_cmd(input logic [7:0] op);
        logic [7:0] d;
        cs_low();
        xfer(op, 1'b0, d);
        cs_high();
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_status", 16'(status_reg), 16'h00);
        chk("rst_oe", 16'(io1_oe), 16'h0);
        chk("rst_out", 16'(io1_out), 16'h0);
        chk("rst_strobe", 16'(cmd_strobe), 16'h0);
        chk("rst_code", 16'(cmd_code), 16'h00);
        ARESETn = 1'b1;
        repeat (2) tick();

        // WREN commit
        strobe_q.push_back(8'h06);
        simple_cmd(8'h06);
        exp_wel = 1'b1;
        chk("wren_status", 16'(status_reg), 16'h02);
        chk("wren_code", 16'(cmd_code), 16'h06);
        chk("wren_strobe_seen", 16'(strobe_q.size()), 16'd0);

        // RDSR streams the register twice
        strobe_q.push_back(8'h05);
        cs_low();
        xfer(8'h05, 1'b0, dummy);
        chk("rdsr_strobe", 16'(cmd_strobe), 16'h1);
        chk("rdsr_oe", 16'(io1_oe), 16'h1);
        rd_byte("rdsr_byte0");
        rd_byte("rdsr_byte1");
        CLOCK = 1'b0;
        tick();
        CS = 1'b1;
        tick();
        chk("rdsr_oe_off", 16'(io1_oe), 16'h0);
        chk("rdsr_out_off", 16'(io1_out), 16'h0);
        tick();
        chk("rdsr_code", 16'(cmd_code), 16'h05);

        // Polling RDSR across a busy window
        busy_req = 1'b1;
        tick();
        busy_req  = 1'b0;
        busy_edge = cyc;
        chk("busy_status", 16'(status_reg), 16'h03);
        strobe_q.push_back(8'h05);
        cs_low();
        xfer(8'h05, 1'b0, dummy);
        for (int n = 0; n < 5; n++) rd_byte("poll_byte");
        cs_high();
        tick();
        busy_edge = -1;
        exp_wel   = 1'b0;
        chk("poll_end_status", 16'(status_reg), 16'h00);

        // Exact busy length
        strobe_q.push_back(8'h06);
        simple_cmd(8'h06);
        chk("wren2_status", 16'(status_reg), 16'h02);
        busy_req = 1'b1;
        tick();
        busy_req = 1'b0;
        repeat (BUSY - 1) tick();
        chk("busy_63", 16'(status_reg), 16'h03);
        tick();
        chk("busy_64", 16'(status_reg), 16'h00);

        // WREN then WRDI
        strobe_q.push_back(8'h06);
        simple_cmd(8'h06);
        chk("wren3_status", 16'(status_reg), 16'h02);
        strobe_q.push_back(8'h04);
        simple_cmd(8'h04);
        chk("wrdi_status", 16'(status_reg), 16'h00);
        chk("wrdi_code", 16'(cmd_code), 16'h04);

        // WREN followed by a ninth rise is dropped
        cs_low();
        xfer(8'h06, 1'b0, dummy);
        CLOCK = 1'b0;
        IO0   = 1'b0;
        tick();
        CLOCK = 1'b1;
        tick();
        cs_high();
        tick();
        chk("nine_rise_status", 16'(status_reg), 16'h00);
        chk("nine_rise_code", 16'(cmd_code), 16'h04);

        // Unknown opcode is ignored
        cs_low();
        xfer(8'hAB, 1'b0, dummy);
        chk("ab_oe", 16'(io1_oe), 16'h0);
        xfer(8'h00, 1'b0, dummy);
        chk("ab_oe_late", 16'(io1_oe), 16'h0);
        chk("ab_out", 16'(io1_out), 16'h0);
        cs_high();
        tick();
        chk("ab_code", 16'(cmd_code), 16'h04);

        // WREN while busy is discarded; reload at count 1 holds WIP
        busy_req = 1'b1;
        tick();
        busy_req  = 1'b0;
        busy_edge = cyc;
        chk("busy2_status", 16'(status_reg), 16'h01);
        simple_cmd(8'h06);
        chk("wren_busy_status", 16'(status_reg), 16'h01);
        chk("wren_busy_code", 16'(cmd_code), 16'h04);
        for (int g = 0; g < 200 && cyc < busy_edge + BUSY - 1; g++) tick();
        chk("cnt1_status", 16'(status_reg), 16'h01);
        busy_req = 1'b1;
        tick();
        busy_req = 1'b0;
        b2 = cyc;
        chk("reload_status", 16'(status_reg), 16'h01);
        busy_edge = -1;
        repeat (BUSY - 1) tick();
        chk("reload_63", 16'(status_reg), 16'h01);
        tick();
        chk("reload_64", 16'(status_reg), 16'h00);
        chk("reload_len", 16'(cyc - b2), 16'(BUSY));

        // Reset during the fourth RDSR bit
        strobe_q.push_back(8'h06);
        simple_cmd(8'h06);
        exp_wel = 1'b1;
        chk("wren4_status", 16'(status_reg), 16'h02);
        strobe_q.push_back(8'h05);
        cs_low();
        xfer(8'h05, 1'b0, dummy);
        for (int k = 0; k < 3; k++) begin
            CLOCK = 1'b0;
            tick();
            CLOCK = 1'b1;
            tick();
        end
        CLOCK = 1'b0;
        tick();
        chk("pre_rst_oe", 16'(io1_oe), 16'h1);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_oe", 16'(io1_oe), 16'h0);
        chk("mid_rst_status", 16'(status_reg), 16'h00);
        chk("mid_rst_out", 16'(io1_out), 16'h0);
        exp_wel = 1'b0;
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
        xfer(8'h06, 1'b0, dummy);
        CLOCK = 1'b0;
        tick();
        CS = 1'b1;
        repeat (2) tick();
        chk("unarmed_status", 16'(status_reg), 16'h00);
        strobe_q.push_back(8'h06);
        simple_cmd(8'h06);
        exp_wel = 1'b1;
        chk("post_rst_status", 16'(status_reg), 16'h02);
        strobe_q.push_back(8'h05);
        cs_low();
        xfer(8'h05, 1'b0, dummy);
        rd_byte("post_rst_byte");
        cs_high();
        tick();

        chk("strobe_q_drained", 16'(strobe_q.size()), 16'd0);
        chk("miso_q_drained", 16'(miso_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
